// File: rtl/sn74ls161_cascade_if.sv
// Counter control/data bundle: load, count enables and preset value in;
// registered count, per-section carries and full terminal count out.
interface sn74ls161_cascade_if #(
    parameter int STAGES = 2
);
    localparam int W = 4 * STAGES;

    logic              ldn;
    logic              enp;
    logic              ent;
    logic [W-1:0]      d;
    logic [W-1:0]      q;
    logic [STAGES-1:0] rco;
    logic              tc;

    modport master (
        output ldn,
        output enp,
        output ent,
        output d,
        input  q,
        input  rco,
        input  tc
    );

    modport slave (
        input  ldn,
        input  enp,
        input  ent,
        input  d,
        output q,
        output rco,
        output tc
    );
endinterface

// File: rtl/sn74ls161_cascade.sv
// Presettable synchronous binary counter made of cascaded 4-bit '161-style
// sections; carries qualify the next section's enable, never its clock.
module sn74ls161_cascade #(
    parameter int STAGES   = 2,
    parameter bit AUTOLOAD = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr,
    sn74ls161_cascade_if.slave   bus
);
    localparam int W = 4 * STAGES;

    logic [W-1:0]      q_reg;
    logic [W-1:0]      q_next;
    logic [W-1:0]      q_inc;
    logic [STAGES-1:0] ent_sec;
    logic [STAGES-1:0] rco_w;
    logic              tc_w;

    // Each section's T enable is the ripple carry of the section below it;
    // it is flattened to "ent and every lower nibble all ones" so the carry
    // chain is not a combinational loop through a vector.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_sec
            if (gi == 0) begin : g_first
                assign ent_sec[gi] = bus.ent;
            end else begin : g_rest
                assign ent_sec[gi] = bus.ent & (&q_reg[4*gi-1:0]);
            end

            assign rco_w[gi] = ent_sec[gi] & (q_reg[4*gi +: 4] == 4'hF);

            assign q_inc[4*gi +: 4] = (bus.enp & ent_sec[gi])
                                    ? q_reg[4*gi +: 4] + 4'd1
                                    : q_reg[4*gi +: 4];
        end
    endgenerate

    assign tc_w = rco_w[STAGES-1];

    // Load wins over autoload, which wins over counting.
    always_comb begin
        q_next = q_inc;
        if (!bus.ldn) begin
            q_next = bus.d;
        end else if (AUTOLOAD && bus.enp && tc_w) begin
            q_next = bus.d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign bus.q   = q_reg;
    assign bus.rco = rco_w;
    assign bus.tc  = tc_w;
endmodule

// File: tb/tb_sn74ls161_cascade.sv
// Randomised and directed checks of the cascaded counter against an
// arithmetic reference model (free-running and autoload instances).
module tb_sn74ls161_cascade;
    localparam int STAGES = 2;
    localparam int W      = 4 * STAGES;
    localparam int MODV   = 1 << W;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    sn74ls161_cascade_if #(.STAGES(STAGES)) bus_a ();
    sn74ls161_cascade_if #(.STAGES(STAGES)) bus_b ();

    sn74ls161_cascade #(.STAGES(STAGES), .AUTOLOAD(1'b0)) dut_a (
        .clk (clk),
        .clr (clr),
        .bus (bus_a)
    );

    sn74ls161_cascade #(.STAGES(STAGES), .AUTOLOAD(1'b1)) dut_b (
        .clk (clk),
        .clr (clr),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int qa_m     = 0;
    int qb_m     = 0;

    // Reference: the counter is just an integer modulo 2^W.
    function automatic int mdl_next(int q, bit ldn, bit enp, bit ent, int d, bit autoload);
        bit tc;
        tc = ent && (q == MODV - 1);
        if (!ldn) return d;
        if (autoload && enp && tc) return d;
        if (enp && ent) return (q + 1) % MODV;
        return q;
    endfunction

    function automatic logic [STAGES-1:0] mdl_rco(int q, bit ent);
        logic [STAGES-1:0] r;
        int m;
        for (int i = 0; i < STAGES; i++) begin
            m = 1 << (4 * (i + 1));
            r[i] = ent && ((q % m) == m - 1);
        end
        return r;
    endfunction

    function automatic bit mdl_tc(int q, bit ent);
        return ent && (q == MODV - 1);
    endfunction

    // Advance both models with the inputs present before the edge, then clock.
    task automatic advance();
        qa_m = mdl_next(qa_m, bus_a.ldn, bus_a.enp, bus_a.ent, int'(bus_a.d), 1'b0);
        qb_m = mdl_next(qb_m, bus_b.ldn, bus_b.enp, bus_b.ent, int'(bus_b.d), 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(bit ldn, bit enp, bit ent, logic [W-1:0] d);
        bus_a.ldn = ldn;
        bus_a.enp = enp;
        bus_a.ent = ent;
        bus_a.d   = d;
    endtask

    task automatic set_b(bit ldn, bit enp, bit ent, logic [W-1:0] d);
        bus_b.ldn = ldn;
        bus_b.enp = enp;
        bus_b.ent = ent;
        bus_b.d   = d;
    endtask

    task automatic test_reset();
        set_a(1'b1, 1'b1, 1'b1, '0);
        set_b(1'b1, 1'b0, 1'b0, '0);
        clr = 1'b1;
        #1;
        n_checks++;
        if (bus_a.q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_q: got %h expected 00", bus_a.q);
        end
        n_checks++;
        if (bus_a.tc !== 1'b0 || bus_a.rco !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_carry: got tc=%b rco=%b expected tc=0 rco=00", bus_a.tc, bus_a.rco);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_a.q !== 8'h00 || bus_b.q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got a=%h b=%h expected 00", bus_a.q, bus_b.q);
        end
        #2;
        clr  = 1'b0;
        qa_m = 0;
        qb_m = 0;
        $display("reset: q=%h tc=%b", bus_a.q, bus_a.tc);
    endtask

    task automatic test_full_count();
        int tc_seen;
        tc_seen = 0;
        set_a(1'b1, 1'b1, 1'b1, '0);
        for (int i = 0; i < 256; i++) begin
            if (bus_a.tc === 1'b1) tc_seen++;
            advance();
            n_checks++;
            if (bus_a.q !== 8'(qa_m) || bus_a.tc !== mdl_tc(qa_m, 1'b1)
                || bus_a.rco !== mdl_rco(qa_m, 1'b1)) begin
                n_fail++;
                $display("FAIL full_count step %0d: got q=%h tc=%b rco=%b expected q=%h tc=%b rco=%b",
                         i, bus_a.q, bus_a.tc, bus_a.rco, 8'(qa_m), mdl_tc(qa_m, 1'b1), mdl_rco(qa_m, 1'b1));
            end
        end
        n_checks++;
        if (bus_a.q !== 8'h00 || tc_seen != 1) begin
            n_fail++;
            $display("FAIL full_count_wrap: got q=%h tc_cycles=%0d expected q=00 tc_cycles=1", bus_a.q, tc_seen);
        end
        $display("full_count: 256 clocks, final q=%h, tc cycles=%0d", bus_a.q, tc_seen);
    endtask

    task automatic test_carry();
        set_a(1'b0, 1'b1, 1'b1, 8'h0E);
        advance();
        set_a(1'b1, 1'b1, 1'b1, 8'h00);
        advance();
        n_checks++;
        if (bus_a.q !== 8'h0F || bus_a.rco !== 2'b01) begin
            n_fail++;
            $display("FAIL carry_0F: got q=%h rco=%b expected q=0F rco=01", bus_a.q, bus_a.rco);
        end
        advance();
        n_checks++;
        if (bus_a.q !== 8'h10 || bus_a.rco !== 2'b00) begin
            n_fail++;
            $display("FAIL carry_10: got q=%h rco=%b expected q=10 rco=00", bus_a.q, bus_a.rco);
        end
        $display("carry: q=%h rco=%b", bus_a.q, bus_a.rco);
    endtask

    task automatic test_load();
        set_a(1'b0, 1'b1, 1'b1, 8'hA5);
        advance();
        n_checks++;
        if (bus_a.q !== 8'hA5) begin
            n_fail++;
            $display("FAIL load_a5: got %h expected a5", bus_a.q);
        end
        set_a(1'b0, 1'b1, 1'b1, 8'hFF);
        advance();
        n_checks++;
        if (bus_a.q !== 8'hFF || bus_a.tc !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ff: got q=%h tc=%b expected q=ff tc=1", bus_a.q, bus_a.tc);
        end
        set_a(1'b0, 1'b1, 1'b1, 8'hA5);
        advance();
        n_checks++;
        if (bus_a.q !== 8'hA5) begin
            n_fail++;
            $display("FAIL load_beats_wrap: got %h expected a5", bus_a.q);
        end
        $display("load: q=%h", bus_a.q);
    endtask

    task automatic test_autoload();
        int pulses;
        int last_pulse;
        pulses     = 0;
        last_pulse = -1;
        set_b(1'b0, 1'b1, 1'b1, 8'hFA);
        advance();
        n_checks++;
        if (bus_b.q !== 8'hFA) begin
            n_fail++;
            $display("FAIL autoload_preset: got %h expected fa", bus_b.q);
        end
        set_b(1'b1, 1'b1, 1'b1, 8'hFA);
        for (int i = 0; i < 18; i++) begin
            if (bus_b.tc === 1'b1) begin
                if (last_pulse >= 0) begin
                    n_checks++;
                    if (i - last_pulse != 6) begin
                        n_fail++;
                        $display("FAIL autoload_period: got %0d expected 6", i - last_pulse);
                    end
                end
                last_pulse = i;
                pulses++;
            end
            advance();
            n_checks++;
            if (bus_b.q !== 8'(qb_m) || bus_b.tc !== mdl_tc(qb_m, 1'b1)) begin
                n_fail++;
                $display("FAIL autoload step %0d: got q=%h tc=%b expected q=%h tc=%b",
                         i, bus_b.q, bus_b.tc, 8'(qb_m), mdl_tc(qb_m, 1'b1));
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL autoload_pulses: got %0d expected 3", pulses);
        end
        $display("autoload: 18 clocks, tc pulses=%0d, q=%h", pulses, bus_b.q);
    endtask

    task automatic test_enp_gating();
        set_a(1'b0, 1'b1, 1'b1, 8'hFF);
        advance();
        set_a(1'b1, 1'b0, 1'b1, 8'h00);
        #1;
        n_checks++;
        if (bus_a.tc !== 1'b1 || bus_a.rco !== 2'b11) begin
            n_fail++;
            $display("FAIL enp0_tc: got tc=%b rco=%b expected tc=1 rco=11", bus_a.tc, bus_a.rco);
        end
        advance();
        n_checks++;
        if (bus_a.q !== 8'hFF || bus_a.tc !== 1'b1) begin
            n_fail++;
            $display("FAIL enp0_hold: got q=%h tc=%b expected q=ff tc=1", bus_a.q, bus_a.tc);
        end
        bus_a.ent = 1'b0;
        #1;
        n_checks++;
        if (bus_a.tc !== 1'b0 || bus_a.rco !== 2'b00) begin
            n_fail++;
            $display("FAIL ent0_tc: got tc=%b rco=%b expected tc=0 rco=00", bus_a.tc, bus_a.rco);
        end
        advance();
        n_checks++;
        if (bus_a.q !== 8'hFF) begin
            n_fail++;
            $display("FAIL ent0_hold: got %h expected ff", bus_a.q);
        end
        $display("enp_gating: q=%h tc=%b", bus_a.q, bus_a.tc);
    endtask

    task automatic test_clr_midcount();
        set_a(1'b0, 1'b1, 1'b1, 8'h37);
        advance();
        set_a(1'b1, 1'b1, 1'b1, 8'h00);
        #3;
        clr = 1'b1;
        #1;
        n_checks++;
        if (bus_a.q !== 8'h00 || bus_a.tc !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_async: got q=%h tc=%b expected q=00 tc=0", bus_a.q, bus_a.tc);
        end
        #1;
        clr  = 1'b0;
        qa_m = 0;
        qb_m = 0;
        advance();
        n_checks++;
        if (bus_a.q !== 8'h01) begin
            n_fail++;
            $display("FAIL clr_resume: got %h expected 01", bus_a.q);
        end
        $display("clr_midcount: q after resume=%h", bus_a.q);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_fail;
        for (int i = 0; i < 300; i++) begin
            set_a(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), 8'($urandom));
            set_b(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), 8'($urandom_range(200, 255)));
            #1;
            n_checks++;
            if (bus_a.rco !== mdl_rco(qa_m, bus_a.ent) || bus_a.tc !== mdl_tc(qa_m, bus_a.ent)
                || bus_b.tc !== mdl_tc(qb_m, bus_b.ent)) begin
                n_fail++;
                $display("FAIL random_carry %0d: got rco=%b tc=%b tcb=%b expected rco=%b tc=%b tcb=%b",
                         i, bus_a.rco, bus_a.tc, bus_b.tc, mdl_rco(qa_m, bus_a.ent),
                         mdl_tc(qa_m, bus_a.ent), mdl_tc(qb_m, bus_b.ent));
            end
            advance();
            n_checks++;
            if (bus_a.q !== 8'(qa_m) || bus_b.q !== 8'(qb_m)) begin
                n_fail++;
                $display("FAIL random_q %0d: got a=%h b=%h expected a=%h b=%h",
                         i, bus_a.q, bus_b.q, 8'(qa_m), 8'(qb_m));
            end
        end
        $display("random: 300 cycles, new failures=%0d", n_fail - errs_before);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1;
        test_reset();
        test_full_count();
        test_carry();
        test_load();
        test_autoload();
        test_enp_gating();
        test_clr_midcount();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
